// File: rtl/alu_pipe_hs_if.sv
// Operation/result handshake bundle between decode, the ALU and writeback.
// master drives operations and consumes results; slave is the ALU side.
interface alu_pipe_hs_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        opcode;
  logic [5:0]        func_field;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              overflow;
  logic              illegal;

  modport master (
    output in_valid, opcode, func_field, a, b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal
  );

  modport slave (
    input  in_valid, opcode, func_field, a, b, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_pipe_hs.sv
// Registered MIPS-style ALU with valid/ready on both sides and an iterative
// shift-add multiplier that occupies the block for DATA_W cycles.
module alu_pipe_hs #(
  parameter int DATA_W = 32,
  parameter int MUL_EN = 1
) (
  input logic          clk,
  input logic          rst_n,
  alu_pipe_hs_if.slave bus
);
  localparam int SHW = $clog2(DATA_W);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(DATA_W - 1);

  typedef enum logic { IDLE, MUL } state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_MUL
  } op_t;

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  state_t            state_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q, overflow_q, illegal_q;
  logic [SHW-1:0]    cnt_q;
  logic [DATA_W-1:0] acc_q, mcand_q, mplier_q;

  op_t                      dec_op;
  logic                     dec_ill;
  logic signed [DATA_W-1:0] a_s, b_s;
  logic [SHW-1:0]           shamt;
  logic [DATA_W-1:0]        sum, diff, alu_res, acc_d;
  logic                     alu_ovf, accept, pop;

  always_comb begin
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    case (bus.opcode)
      6'h00: begin
        case (bus.func_field)
          6'h20: dec_op = OP_ADD;
          6'h22: dec_op = OP_SUB;
          6'h24: dec_op = OP_AND;
          6'h25: dec_op = OP_OR;
          6'h27: dec_op = OP_NOR;
          6'h2A: dec_op = OP_SLT;
          6'h2B: dec_op = OP_SLTU;
          6'h00: dec_op = OP_SLL;
          6'h02: dec_op = OP_SRL;
          6'h03: dec_op = OP_SRA;
          6'h18: begin
            if (MUL_EN != 0) dec_op = OP_MUL;
            else             dec_ill = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      6'h04, 6'h05: dec_op = OP_SUB;
      6'h23, 6'h2B: dec_op = OP_ADD;
      default:      dec_ill = 1'b1;
    endcase
  end

  assign a_s   = bus.a;
  assign b_s   = bus.b;
  assign shamt = bus.b[SHW-1:0];
  assign sum   = bus.a + bus.b;
  assign diff  = bus.a - bus.b;

  always_comb begin
    alu_res = sum;
    alu_ovf = 1'b0;
    case (dec_op)
      OP_ADD:  begin alu_res = sum;  alu_ovf = add_ovf(bus.a[DATA_W-1], bus.b[DATA_W-1], sum[DATA_W-1]); end
      OP_SUB:  begin alu_res = diff; alu_ovf = sub_ovf(bus.a[DATA_W-1], bus.b[DATA_W-1], diff[DATA_W-1]); end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (bus.a < bus.b)};
      OP_SLL:  alu_res = bus.a << shamt;
      OP_SRL:  alu_res = bus.a >> shamt;
      OP_SRA:  alu_res = DATA_W'(a_s >>> shamt);
      default: alu_res = sum;
    endcase
  end

  // Ready depends only on registered state and the downstream ready, never on in_valid.
  assign bus.in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = out_valid_q && bus.out_ready;
  assign acc_d        = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
    end else begin
      if (pop) out_valid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (accept) begin
          if (dec_op == OP_MUL) begin
            state_q  <= MUL;
            mcand_q  <= bus.a;
            mplier_q <= bus.b;
            acc_q    <= '0;
            cnt_q    <= '0;
          end else begin
            result_q    <= alu_res;
            zero_q      <= (alu_res == '0);
            overflow_q  <= alu_ovf;
            illegal_q   <= dec_ill;
            out_valid_q <= 1'b1;
          end
        end
      end else begin
        // One partial product per cycle; the last step loads the result directly.
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          result_q    <= acc_d;
          zero_q      <= (acc_d == '0);
          overflow_q  <= 1'b0;
          illegal_q   <= 1'b0;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.illegal   = illegal_q;
endmodule
